// File: rtl/uart_pkg.sv
// Shared types and timing helpers for the UART blocks.
// Holds the receiver state encoding and the default line rate.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

  localparam int CLK_HZ = 50_000_000;
  localparam int BAUD   = 9600;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter pacing bit periods; tick marks the terminal count.
// Shared by the receiver and transmitter.
module bit_timer #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic half,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LD = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n)
      cnt <= '0;
    else if (start)
      cnt <= half ? HALF_LD : FULL_LD;
    else if (cnt != '0)
      cnt <= cnt - CNT_W'(1);
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver with a one-entry read buffer, framing-error pulse
// and sticky overrun flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD),
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 full,
  input  logic                 rd,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  rx_state_t state, next_state;

  logic                 rx_p0, rx_p1, rx_s;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 tick;
  logic                 timer_start, timer_half;
  logic                 sample_bit, load_byte, set_overrun, set_ferr;

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (timer_start),
    .half    (timer_half),
    .tick    (tick)
  );

  // Stage p0 -> p1: two-flop synchronizer, idles high through reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      state <= IDLE;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
      state <= next_state;
    end
  end

  assign rx_s = rx_p1;

  always_comb begin
    next_state  = state;
    timer_start = 1'b0;
    timer_half  = 1'b0;
    sample_bit  = 1'b0;
    load_byte   = 1'b0;
    set_overrun = 1'b0;
    set_ferr    = 1'b0;
    case (state)
      IDLE: if (!rx_s) begin
        next_state  = START;
        timer_start = 1'b1;
        timer_half  = 1'b1;
      end
      START: if (tick) begin
        if (rx_s) begin
          next_state = IDLE;
        end else begin
          next_state  = DATA;
          timer_start = 1'b1;
        end
      end
      DATA: if (tick) begin
        sample_bit  = 1'b1;
        timer_start = 1'b1;
        if (bit_idx == LAST_IDX)
          next_state = STOP;
      end
      STOP: if (tick) begin
        if (rx_s) begin
          next_state = IDLE;
          // A read in the same cycle frees the slot, so the new byte is kept
          if (!full || rd)
            load_byte = 1'b1;
          else
            set_overrun = 1'b1;
        end else begin
          next_state = BREAK;
          set_ferr   = 1'b1;
        end
      end
      BREAK: if (rx_s) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bit_idx   <= '0;
      shift     <= '0;
      data      <= '0;
      full      <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= set_ferr;
      if (state != DATA)
        bit_idx <= '0;
      else if (sample_bit) begin
        shift[bit_idx] <= rx_s;
        bit_idx        <= bit_idx + IDX_W'(1);
      end
      if (load_byte)
        data <= shift;
      if (load_byte)
        full <= 1'b1;
      else if (rd)
        full <= 1'b0;
      if (set_overrun)
        overrun <= 1'b1;
      else if (rd)
        overrun <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed table, corner sequences and
// randomized frames against a frame-level buffer model.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int DB  = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          rx = 1'b1;
  logic          rd = 1'b0;
  logic [DB-1:0] data;
  logic          full, frame_err, overrun, busy;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (rx),
    .data      (data),
    .full      (full),
    .rd        (rd),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   ferr_cnt = 0;
  logic ferr_long = 1'b0;
  logic ferr_q = 1'b0;
  logic full_q = 1'b0;
  int   rise_cyc = -1;

  always @(negedge clk) begin
    if (frame_err) begin
      if (ferr_q) ferr_long <= 1'b1;
      else        ferr_cnt  <= ferr_cnt + 1;
    end
    ferr_q <= frame_err;
    full_q <= full;
    if (full && !full_q) rise_cyc <= cyc;
  end

  int errors = 0;
  int checks = 0;
  int start_cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rx = 1'b1;
    rd = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  // Drives one frame; rd / reset_n are pulsed so they are sampled on edge rd_at / rst_at
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int rd_at, input int rst_at);
    logic [9:0] syms;
    int n;
    syms = {stop, b, 1'b0};
    n = 0;
    start_cyc = cyc + 1;
    for (int s = 0; s < 10; s++) begin
      rx = syms[s];
      for (int c = 0; c < CPB; c++) begin
        step();
        n++;
        if (n == rd_at - 1) rd = 1'b1;
        else if (n == rd_at) rd = 1'b0;
        if (n == rst_at - 1) reset_n = 1'b0;
        else if (n == rst_at) reset_n = 1'b1;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (busy && t < 60) begin
      step();
      t++;
    end
    check(name, int'(busy), 0);
  endtask

  task automatic rd_pulse();
    rd = 1'b1;
    step();
    rd = 1'b0;
    step();
  endtask

  typedef struct {
    logic [7:0] byte_v;
    logic       stop_v;
    logic       rd_after;
    logic       exp_full;
    logic [7:0] exp_data;
    logic       exp_ovr;
    int         exp_ferr;
    logic       chk_lat;
  } vec_t;

  vec_t vecs [6];

  logic       m_full, m_ovr;
  logic [7:0] m_data;

  initial begin
    int base, lat;
    logic [7:0] b;
    logic stp;

    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 0, 1'b1};
    vecs[1] = '{8'h5A, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 0, 1'b0};
    vecs[2] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 0, 1'b0};
    vecs[4] = '{8'h81, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 0, 1'b0};
    vecs[5] = '{8'hC3, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b0, 0, 1'b0};

    step();
    do_reset();
    check("rst_data", int'(data), 0);
    check("rst_full", int'(full), 0);
    check("rst_ferr", int'(frame_err), 0);
    check("rst_ovr", int'(overrun), 0);
    check("rst_busy", int'(busy), 0);

    // Short low glitch must be rejected at the mid-start sample
    base = ferr_cnt;
    rx = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("glitch_busy", int'(busy), 1);
    rx = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("glitch_idle", int'(busy), 0);
    check("glitch_full", int'(full), 0);
    check("glitch_data", int'(data), 0);
    check("glitch_ferr", ferr_cnt - base, 0);

    foreach (vecs[i]) begin
      base = ferr_cnt;
      send_frame(vecs[i].byte_v, vecs[i].stop_v, 0, 0);
      rx = 1'b1;
      wait_idle($sformatf("v%0d_idle", i));
      check($sformatf("v%0d_full", i), int'(full), int'(vecs[i].exp_full));
      check($sformatf("v%0d_data", i), int'(data), int'(vecs[i].exp_data));
      check($sformatf("v%0d_ovr", i), int'(overrun), int'(vecs[i].exp_ovr));
      check($sformatf("v%0d_ferr", i), ferr_cnt - base, vecs[i].exp_ferr);
      if (vecs[i].chk_lat) begin
        lat = rise_cyc - start_cyc;
        check("v_latency_ok", int'(lat >= 2 + CPB/2 + 9*CPB - 1 && lat <= 2 + CPB/2 + 9*CPB + 1), 1);
      end
      if (vecs[i].rd_after) begin
        rd_pulse();
        check($sformatf("v%0d_rd_full", i), int'(full), 0);
        check($sformatf("v%0d_rd_ovr", i), int'(overrun), 0);
      end
    end

    // Stop bit low followed by a long break
    base = ferr_cnt;
    send_frame(8'h3C, 1'b0, 0, 0);
    for (int i = 0; i < 40; i++) step();
    check("brk_busy", int'(busy), 1);
    check("brk_ferr", ferr_cnt - base, 1);
    check("brk_full", int'(full), 0);
    rx = 1'b1;
    wait_idle("brk_idle");
    send_frame(8'h11, 1'b1, 0, 0);
    wait_idle("b11_idle");
    check("b11_full", int'(full), 1);
    check("b11_data", int'(data), 8'h11);
    rd_pulse();

    // Back-to-back frames without a read
    send_frame(8'h01, 1'b1, 0, 0);
    send_frame(8'h02, 1'b1, 0, 0);
    wait_idle("ovr_idle");
    check("ovr_data", int'(data), 8'h01);
    check("ovr_flag", int'(overrun), 1);
    rd_pulse();
    check("ovr_rd_full", int'(full), 0);
    check("ovr_rd_flag", int'(overrun), 0);

    // Read coincident with the load edge
    send_frame(8'h55, 1'b1, 0, 0);
    wait_idle("h55_idle");
    check("h55_data", int'(data), 8'h55);
    send_frame(8'h7E, 1'b1, 2 + CPB/2 + 9*CPB + 1, 0);
    wait_idle("same_idle");
    check("same_data", int'(data), 8'h7E);
    check("same_full", int'(full), 1);
    check("same_ovr", int'(overrun), 0);

    // Reset mid-data abandons the frame and clears held state
    send_frame(8'hFF, 1'b1, 0, 60);
    check("mrst_data", int'(data), 0);
    check("mrst_full", int'(full), 0);
    check("mrst_ovr", int'(overrun), 0);
    check("mrst_busy", int'(busy), 0);
    send_frame(8'h42, 1'b1, 0, 0);
    wait_idle("b42_idle");
    check("b42_data", int'(data), 8'h42);
    check("b42_full", int'(full), 1);

    // Randomized frames against the buffer model
    do_reset();
    m_full = 1'b0;
    m_ovr  = 1'b0;
    m_data = 8'h00;
    for (int k = 0; k < 12; k++) begin
      b   = 8'($urandom_range(0, 255));
      stp = ($urandom_range(0, 4) != 0);
      base = ferr_cnt;
      send_frame(b, stp, 0, 0);
      rx = 1'b1;
      wait_idle($sformatf("r%0d_idle", k));
      if (stp) begin
        if (!m_full) begin
          m_data = b;
          m_full = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end
      check($sformatf("r%0d_full", k), int'(full), int'(m_full));
      check($sformatf("r%0d_data", k), int'(data), int'(m_data));
      check($sformatf("r%0d_ovr", k), int'(overrun), int'(m_ovr));
      check($sformatf("r%0d_ferr", k), ferr_cnt - base, stp ? 0 : 1);
      if ($urandom_range(0, 1) == 1) begin
        rd_pulse();
        m_full = 1'b0;
        m_ovr  = 1'b0;
      end
      repeat ($urandom_range(0, 5)) step();
    end

    check("ferr_one_cycle", int'(ferr_long), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
